// File: rtl/drive_pkg.sv
// Shared constants for the desired-drive pipeline.
// Defaults for widths, offsets and saturation limits.
package drive_pkg;

  localparam int DEF_TORQUE_W  = 12;
  localparam int DEF_INCLINE_W = 13;
  localparam int DEF_CUR_W     = 12;

  localparam int DEF_TORQUE_MIN = 'h380;

  localparam int INC_MIN = -512;
  localparam int INC_MAX = 511;
  localparam int INC_OFS = 256;
  localparam int LIM_MAX = 511;

  localparam int CAD_THR = 1;
  localparam int CAD_OFS = 32;

  localparam int PIPE_DEPTH = 4;

endpackage

// File: rtl/drive_slew_lim.sv
// Output stage: slew-rate limits the raw current target.
// Steps are asymmetric; not-pedaling samples fall faster.
module drive_slew_lim #(
  parameter int CUR_W      = 12,
  parameter int UP_STEP    = 64,
  parameter int DN_STEP    = 128,
  parameter int DN_STEP_NP = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vld,
  input  logic             np,
  input  logic [CUR_W-1:0] raw,
  output logic [CUR_W-1:0] cur,
  output logic             out_vld,
  output logic             at_target
);

  localparam int W = CUR_W + 1;

  logic [W-1:0] c;
  logic [W-1:0] r;
  logic [W-1:0] up;
  logic [W-1:0] dn;
  logic [W-1:0] step;
  logic [W-1:0] nxt;

  // One guard bit keeps the sums clear of wrap at 0 and full scale
  always_comb begin
    c    = {1'b0, cur};
    r    = {1'b0, raw};
    step = np ? W'(DN_STEP_NP) : W'(DN_STEP);
    up   = c + W'(UP_STEP);
    dn   = (c > step) ? c - step : '0;
    nxt  = c;
    if (r > c) begin
      nxt = (r < up) ? r : up;
    end else begin
      nxt = (r > dn) ? r : dn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= '0;
      out_vld   <= 1'b0;
      at_target <= 1'b1;
    end else begin
      out_vld <= vld;
      if (vld) begin
        cur       <= nxt[CUR_W-1:0];
        at_target <= (nxt == r);
      end
    end
  end

endmodule

// File: rtl/desired_drive_pipe.sv
// Four-stage pipeline from conditioned sensor samples
// to a slew-limited motor current target.
module desired_drive_pipe
  import drive_pkg::*;
#(
  parameter int TORQUE_W   = DEF_TORQUE_W,
  parameter int INCLINE_W  = DEF_INCLINE_W,
  parameter int CUR_W      = DEF_CUR_W,
  parameter int TORQUE_MIN = DEF_TORQUE_MIN,
  parameter int PROD_SHIFT = 15,
  parameter int UP_STEP    = 64,
  parameter int DN_STEP    = 128,
  parameter int DN_STEP_NP = 512
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_vld,
  input  logic [TORQUE_W-1:0]  avg_torque,
  input  logic [4:0]           cadence,
  input  logic                 not_pedaling,
  input  logic [INCLINE_W-1:0] incline,
  input  logic [2:0]           scale,
  output logic [CUR_W-1:0]     target_curr,
  output logic                 out_vld,
  output logic                 at_target
);

  localparam int P1W = TORQUE_W + 3;
  localparam int P2W = 15;
  localparam int PW  = P1W + P2W;

  localparam logic signed [INCLINE_W-1:0] IMAX = INCLINE_W'(INC_MAX);
  localparam logic signed [INCLINE_W-1:0] IMIN = INCLINE_W'(INC_MIN);

  typedef struct packed {
    logic                np;
    logic [TORQUE_W-1:0] tq;
    logic [2:0]          sc;
    logic [8:0]          lim;
    logic [5:0]          cad;
  } s1_t;

  typedef struct packed {
    logic           np;
    logic [P1W-1:0] p1;
    logic [P2W-1:0] p2;
  } s2_t;

  typedef struct packed {
    logic             np;
    logic [CUR_W-1:0] raw;
  } s3_t;

  logic v1, v2, v3;
  s1_t  s1, s1_n;
  s2_t  s2, s2_n;
  s3_t  s3, s3_n;

  logic signed [INCLINE_W-1:0] inc_s;
  logic signed [9:0]           inc_sat;
  logic signed [10:0]          inc_fac;
  logic [PW-1:0]               prod;
  logic                        ovf;

  always_comb begin
    inc_s = incline;
    if (inc_s > IMAX) begin
      inc_sat = 10'(INC_MAX);
    end else if (inc_s < IMIN) begin
      inc_sat = 10'(INC_MIN);
    end else begin
      inc_sat = inc_s[9:0];
    end
    inc_fac = {inc_sat[9], inc_sat} + 11'(INC_OFS);

    s1_n.np = not_pedaling;
    s1_n.sc = scale;
    if (inc_fac[10]) begin
      s1_n.lim = '0;
    end else if (inc_fac > 11'(LIM_MAX)) begin
      s1_n.lim = 9'(LIM_MAX);
    end else begin
      s1_n.lim = inc_fac[8:0];
    end
    s1_n.cad = (cadence > 5'(CAD_THR))
             ? 6'(cadence) + 6'(CAD_OFS) : '0;
    s1_n.tq  = (avg_torque > TORQUE_W'(TORQUE_MIN))
             ? avg_torque - TORQUE_W'(TORQUE_MIN) : '0;
  end

  always_comb begin
    s2_n.np = s1.np;
    s2_n.p1 = P1W'(s1.tq) * P1W'(s1.sc);
    s2_n.p2 = P2W'(s1.lim) * P2W'(s1.cad);
  end

  // Anything above the output window saturates to full scale
  always_comb begin
    prod    = PW'(s2.p1) * PW'(s2.p2);
    ovf     = (prod >> (PROD_SHIFT + CUR_W)) != '0;
    s3_n.np = s2.np;
    if (s2.np) begin
      s3_n.raw = '0;
    end else if (ovf) begin
      s3_n.raw = '1;
    end else begin
      s3_n.raw = prod[PROD_SHIFT +: CUR_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      v1 <= in_vld;
      v2 <= v1;
      v3 <= v2;
      if (in_vld) s1 <= s1_n;
      if (v1)     s2 <= s2_n;
      if (v2)     s3 <= s3_n;
    end
  end

  drive_slew_lim #(
    .CUR_W      (CUR_W),
    .UP_STEP    (UP_STEP),
    .DN_STEP    (DN_STEP),
    .DN_STEP_NP (DN_STEP_NP)
  ) u_slew (
    .clk       (clk),
    .rst_n     (rst_n),
    .vld       (v3),
    .np        (s3.np),
    .raw       (s3.raw),
    .cur       (target_curr),
    .out_vld   (out_vld),
    .at_target (at_target)
  );

endmodule

// File: tb/tb_desired_drive_pipe.sv
// Directed bench for desired_drive_pipe: vector table
// plus gapped-strobe and mid-flight reset sequences.
module tb_desired_drive_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_vld;
  logic [11:0] avg_torque;
  logic [4:0]  cadence;
  logic        not_pedaling;
  logic [12:0] incline;
  logic [2:0]  scale;
  logic [11:0] target_curr;
  logic        out_vld;
  logic        at_target;

  desired_drive_pipe dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_vld       (in_vld),
    .avg_torque   (avg_torque),
    .cadence      (cadence),
    .not_pedaling (not_pedaling),
    .incline      (incline),
    .scale        (scale),
    .target_curr  (target_curr),
    .out_vld      (out_vld),
    .at_target    (at_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [11:0] tq;
    logic [4:0]  cad;
    logic        np;
    logic [12:0] inc;
    logic [2:0]  sc;
    logic [11:0] ecur;
    logic        eat;
  } vec_t;

  typedef struct {
    logic        v;
    logic [11:0] ecur;
    logic        eat;
  } exp_t;

  vec_t        tbl[$];
  exp_t        pend[$];
  int          checks = 0;
  int          errors = 0;
  logic [11:0] hold_cur = '0;
  logic        hold_at = 1'b1;

  function automatic vec_t mk(logic v, logic [11:0] tq,
                              logic [4:0] cad, logic np,
                              logic [12:0] inc, logic [2:0] sc,
                              logic [11:0] ecur, logic eat);
    vec_t r;
    r.v = v; r.tq = tq; r.cad = cad; r.np = np;
    r.inc = inc; r.sc = sc; r.ecur = ecur; r.eat = eat;
    return r;
  endfunction

  function automatic vec_t nom(logic [11:0] e, logic a);
    return mk(1, 12'h480, 5'd16, 0, 13'h0, 3'd3, e, a);
  endfunction

  function automatic vec_t sat(logic np, logic [11:0] e, logic a);
    return mk(1, 12'hFFF, 5'd31, np, 13'h0FF0, 3'd7, e, a);
  endfunction

  function automatic vec_t idle(int k);
    if (k % 2 == 0)
      return mk(0, 12'hFFF, 5'd31, 1, 13'h1E00, 3'd7, 0, 0);
    return mk(0, 12'h000, 5'd0, 0, 13'h0FF0, 3'd0, 0, 0);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // Output for a row driven 4 negedges ago is checked here.
  task automatic cyc(input vec_t r);
    exp_t e;
    @(negedge clk);
    if (pend.size() == 4) begin
      e = pend.pop_front();
      chk("out_vld", {31'd0, out_vld}, {31'd0, e.v});
      if (e.v) begin
        chk("target_curr", {20'd0, target_curr}, {20'd0, e.ecur});
        chk("at_target", {31'd0, at_target}, {31'd0, e.eat});
        hold_cur = e.ecur;
        hold_at  = e.eat;
      end else begin
        chk("hold_curr", {20'd0, target_curr}, {20'd0, hold_cur});
        chk("hold_at", {31'd0, at_target}, {31'd0, hold_at});
      end
    end else begin
      chk("out_vld_empty", {31'd0, out_vld}, 32'd0);
      chk("hold_curr_empty", {20'd0, target_curr}, {20'd0, hold_cur});
    end
    in_vld       = r.v;
    avg_torque   = r.tq;
    cadence      = r.cad;
    not_pedaling = r.np;
    incline      = r.inc;
    scale        = r.sc;
    pend.push_back('{r.v, r.ecur, r.eat});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t zv[4];
    int   c;

    rst_n = 1'b0;
    in_vld = 0; avg_torque = '0; cadence = '0;
    not_pedaling = 0; incline = '0; scale = '0;
    repeat (2) @(negedge clk);
    chk("rst_curr", {20'd0, target_curr}, 32'd0);
    chk("rst_vld", {31'd0, out_vld}, 32'd0);
    chk("rst_at", {31'd0, at_target}, 32'd1);
    rst_n = 1'b1;

    tbl.push_back(nom(12'd64, 0));
    tbl.push_back(nom(12'd128, 0));
    tbl.push_back(nom(12'd192, 0));
    tbl.push_back(nom(12'd256, 0));
    tbl.push_back(nom(12'd288, 1));
    for (int i = 0; i < 4; i++) tbl.push_back(idle(i));

    zv[0] = mk(1, 12'h480, 5'd16, 0, 13'h1E00, 3'd3, 0, 0);
    zv[1] = mk(1, 12'h480, 5'd1,  0, 13'h0,    3'd3, 0, 0);
    zv[2] = mk(1, 12'h37F, 5'd16, 0, 13'h0,    3'd3, 0, 0);
    zv[3] = mk(1, 12'h480, 5'd16, 0, 13'h0,    3'd0, 0, 0);
    for (int z = 0; z < 4; z++) begin
      zv[z].ecur = 12'd160; zv[z].eat = 0; tbl.push_back(zv[z]);
      zv[z].ecur = 12'd32;  zv[z].eat = 0; tbl.push_back(zv[z]);
      zv[z].ecur = 12'd0;   zv[z].eat = 1; tbl.push_back(zv[z]);
      tbl.push_back(nom(12'd64, 0));
      tbl.push_back(nom(12'd128, 0));
      tbl.push_back(nom(12'd192, 0));
      tbl.push_back(nom(12'd256, 0));
      tbl.push_back(nom(12'd288, 1));
    end

    for (int k = 1; k <= 62; k++) begin
      c = 288 + 64 * k;
      if (c > 4095) c = 4095;
      tbl.push_back(sat(0, 12'(c), c == 4095));
    end

    for (int j = 1; j <= 8; j++) begin
      c = (j == 8) ? 0 : 4095 - 512 * j;
      tbl.push_back(sat(1, 12'(c), j == 8));
    end

    for (int k = 1; k <= 16; k++) tbl.push_back(sat(0, 12'(64 * k), 0));
    tbl.push_back(sat(1, 12'd512, 0));
    tbl.push_back(sat(0, 12'd576, 0));
    tbl.push_back(sat(0, 12'd640, 0));

    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i]);

    cyc(nom(12'd512, 0)); cyc(idle(0)); cyc(idle(1));
    cyc(nom(12'd384, 0)); cyc(idle(0)); cyc(idle(1));
    cyc(nom(12'd288, 1)); cyc(idle(0)); cyc(idle(1));
    for (int i = 0; i < 4; i++) cyc(idle(i));

    cyc(sat(0, 12'd0, 0));
    cyc(sat(0, 12'd0, 0));
    cyc(sat(0, 12'd0, 0));
    @(negedge clk);
    rst_n  = 1'b0;
    in_vld = 1'b0;
    #1;
    chk("midrst_curr", {20'd0, target_curr}, 32'd0);
    chk("midrst_vld", {31'd0, out_vld}, 32'd0);
    chk("midrst_at", {31'd0, at_target}, 32'd1);
    pend.delete();
    hold_cur = '0;
    hold_at  = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) cyc(idle(i));
    cyc(nom(12'd64, 0));
    for (int i = 0; i < 4; i++) cyc(idle(i));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/desired_drive_pipe.md
# desired_drive_pipe

Parametrised, fully pipelined successor to the combinational-tail desired-drive computation. It sits between the sensor-conditioning front end (avg torque, cadence, incline, pedaling detect) and the brushless current loop. It turns each valid sample into a motor current target, with a valid strobe and a slew-rate limiter on the output, so the loop never sees step changes in demand. Pipeline depth is fixed at 4; all widths and slew steps are parameters.

## Interface
- TORQUE_W, 12, avg_torque width
- INCLINE_W, 13, signed incline width
- CUR_W, 12, target_curr width
- TORQUE_MIN, 12'h380, torque offset subtracted before scaling
- PROD_SHIFT, 15, right shift applied to the full product
- UP_STEP, 64, max increase of target_curr per valid update
- DN_STEP, 128, max decrease per update while pedaling
- DN_STEP_NP, 512, max decrease per update while not pedaling
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous and active-low
- in_vld  in  1  sample strobe; inputs below are captured when high
- avg_torque  in  TORQUE_W  unsigned filtered torque
- cadence  in  5  unsigned cadence
- not_pedaling  in  1  forces zero demand for this sample
- incline  in  INCLINE_W  signed incline
- scale  in  3  assist level 0..7
- target_curr  out  CUR_W  slew-limited current target
- out_vld  out  1  one-cycle pulse when target_curr has just updated
- at_target  out  1  high when the last update was not slew-limited

## Operation
- S1, on in_vld: incline saturated to signed 10-bit [-512,511]; incline_factor = sat + 256 in 11-bit signed; incline_lim = 0 if negative, 511 if >511, else factor. cadence_factor = (cadence > 1) ? cadence + 32 : 0 (6 bits). torque_pos = max(avg_torque - TORQUE_MIN, 0). not_pedaling is registered alongside these values.
- S2: p1 = torque_pos * scale (TORQUE_W+3 bits); p2 = incline_lim * cadence_factor (15 bits).
- S3: prod = p1 * p2. raw = 0 if np. raw = all-ones CUR_W if prod >> PROD_SHIFT ≥ 2^CUR_W. Otherwise raw = prod[PROD_SHIFT +: CUR_W].
- S4, slew limiter:
  - If raw > cur, cur = min(raw, cur + UP_STEP).
  - Otherwise cur = max(raw, cur - step), where step = DN_STEP_NP if np else DN_STEP.
  - Computed in CUR_W+1 bits with no wrap at 0 or full scale.
  - at_target = (cur_next == raw).
- A valid bit travels with each stage. Stage registers load only when their incoming valid is high; otherwise they hold.
- target_curr and at_target change only on an S4 update.

## Timing
- Reset: all valid bits 0, target_curr 0, out_vld 0, at_target 1, and all stage data registers 0. Reset applied mid-pipeline discards in-flight samples.
- Latency: in_vld at cycle N produces an out_vld pulse and updated target_curr at N+4, visible after that edge.
- Throughput is one sample per cycle. Back-to-back in_vld produces back-to-back out_vld, each slewed from the previous result.
- Gaps in in_vld propagate unchanged. The slew state is held across gaps, and no decay happens without samples.
- Inputs are sampled only at the in_vld edge. Changes between strobes have no effect.

## Structure
- drive_pkg holds:
  - default width constants;
  - TORQUE_MIN;
  - the incline saturation limits (-512/511) and the +256 offset;
  - the cadence threshold and +32 offset.
- The sub-module is drive_slew_lim (S4): parametrised by CUR_W and the three step sizes. Inputs: clk, rst_n, vld, np, raw. Outputs: cur, out_vld, at_target.
- S1–S3 stay in the top module.

## Test plan
- Nominal ramp: torque 0x480, scale 3, incline 0, cadence 16, np=0, in_vld for 5 consecutive cycles. Raw is 288 (prod 9437184 >> 15). Outputs 64, 128, 192, 256, 288 on cycles N+4..N+8; at_target high only on the last.
- Saturation: torque 0xFFF, scale 7, incline 13'h0FF0, cadence 31. Raw is 0xFFF. After enough samples target_curr is 0xFFF and does not wrap.
- Zero terms, each from steady 288 and each giving raw 0. Cases: incline 13'h1E00 (-512); cadence 1; torque 0x37F; scale 0. Each sample lowers output by 128 to 160, then 32, then 0, with no underflow.
- not_pedaling: from steady 0xFFF, np=1 samples step down by 512 per update to 0 in 8 updates. A single np sample mid-ramp drops output by 512 only once.
- Gapped strobes: in_vld every 3rd cycle. out_vld pulses exactly 4 cycles after each strobe. Input toggles between strobes have no effect.
- Reset mid-operation: assert rst_n low while 3 samples are in flight. Outputs go to 0 immediately and no out_vld appears after release. The first new sample ramps from 0.
